// File: rtl/battle_damage_calc_if.sv
// battle_damage_calc_if: bundles the attack request, HP load and result signals of the damage block.
interface battle_damage_calc_if #(
    parameter int HP_W    = 8,
    parameter int POWER_W = 8
);
    logic               load_hp;
    logic [HP_W-1:0]    hp_init_player;
    logic [HP_W-1:0]    hp_init_enemy;
    logic               start;
    logic               attacker_side;
    logic [2:0]         atk_type;
    logic [2:0]         def_type;
    logic [POWER_W-1:0] move_power;
    logic               tick;
    logic               busy;
    logic               done;
    logic [1:0]         effect;
    logic [POWER_W:0]   damage;
    logic [HP_W-1:0]    hp_player;
    logic [HP_W-1:0]    hp_enemy;
    logic               fainted_player;
    logic               fainted_enemy;

    modport master (
        output load_hp, hp_init_player, hp_init_enemy, start, attacker_side,
               atk_type, def_type, move_power, tick,
        input  busy, done, effect, damage, hp_player, hp_enemy,
               fainted_player, fainted_enemy
    );

    modport slave (
        input  load_hp, hp_init_player, hp_init_enemy, start, attacker_side,
               atk_type, def_type, move_power, tick,
        output busy, done, effect, damage, hp_player, hp_enemy,
               fainted_player, fainted_enemy
    );
endinterface

// File: rtl/battle_damage_calc.sv
// battle_damage_calc: type-chart lookup, move damage, and per-tick HP drain of the defender.
module battle_damage_calc #(
    parameter int HP_W         = 8,
    parameter int POWER_W      = 8,
    parameter int TICKS_PER_HP = 1
) (
    input logic i_clk,
    input logic i_rst_n,
    battle_damage_calc_if.slave bus
);
    localparam int TW = (TICKS_PER_HP > 1) ? $clog2(TICKS_PER_HP) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CALC, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic               r_side;
    logic [2:0]         r_atk, r_def;
    logic [POWER_W-1:0] r_power;
    logic [3:0]         r_mult;
    logic [1:0]         r_eff_pend, r_effect;
    logic [POWER_W:0]   r_damage, r_rem;
    logic [HP_W-1:0]    r_hp_p, r_hp_e;
    logic [TW-1:0]      r_tcnt;

    logic [1:0]         w_eff;
    logic [3:0]         w_mult;
    logic [POWER_W+3:0] w_prod;
    logic [POWER_W:0]   w_raw, w_dmg;
    logic [HP_W-1:0]    w_def_hp;
    logic               w_drain_end, w_step;

    // Octal literal reads as {attacker, defender} type codes.
    always_comb begin
        w_eff = 2'b00;
        case ({r_atk, r_def})
            6'o02, 6'o05, 6'o10, 6'o21, 6'o25, 6'o32, 6'o34, 6'o40, 6'o51, 6'o54: w_eff = 2'b01;
            6'o00, 6'o01, 6'o04, 6'o11, 6'o12, 6'o15, 6'o20, 6'o22, 6'o30, 6'o33,
            6'o43, 6'o45, 6'o65: w_eff = 2'b10;
            default: w_eff = 2'b00;
        endcase
    end

    assign w_mult      = (w_eff == 2'b01) ? 4'd8 : (w_eff == 2'b10) ? 4'd2 : 4'd4;
    assign w_prod      = {4'b0, r_power} * {{POWER_W{1'b0}}, r_mult};
    assign w_raw       = w_prod[POWER_W+2:2];
    assign w_dmg       = (r_power != '0 && w_raw == '0) ? {{POWER_W{1'b0}}, 1'b1} : w_raw;
    assign w_def_hp    = r_side ? r_hp_p : r_hp_e;
    assign w_drain_end = (r_rem == '0) || (w_def_hp == '0);
    assign w_step      = bus.tick && (r_tcnt == TW'(TICKS_PER_HP - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start && !bus.load_hp) w_next = S_LOOKUP;
            S_LOOKUP: w_next = S_CALC;
            S_CALC:   w_next = (w_dmg == '0) ? S_DONE : S_DRAIN;
            S_DRAIN:  if (w_drain_end) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_side     <= 1'b0;
            r_atk      <= '0;
            r_def      <= '0;
            r_power    <= '0;
            r_mult     <= '0;
            r_eff_pend <= '0;
            r_effect   <= '0;
            r_damage   <= '0;
            r_rem      <= '0;
            r_hp_p     <= '0;
            r_hp_e     <= '0;
            r_tcnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load_hp) begin
                        r_hp_p <= bus.hp_init_player;
                        r_hp_e <= bus.hp_init_enemy;
                    end else if (bus.start) begin
                        r_side  <= bus.attacker_side;
                        r_atk   <= bus.atk_type;
                        r_def   <= bus.def_type;
                        r_power <= bus.move_power;
                    end
                end
                S_LOOKUP: begin
                    r_mult     <= w_mult;
                    r_eff_pend <= w_eff;
                end
                S_CALC: begin
                    r_damage <= w_dmg;
                    r_effect <= r_eff_pend;
                    r_rem    <= w_dmg;
                    r_tcnt   <= '0;
                end
                S_DRAIN: begin
                    if (!w_drain_end && bus.tick) begin
                        if (w_step) begin
                            if (r_side) r_hp_p <= r_hp_p - 1'b1;
                            else        r_hp_e <= r_hp_e - 1'b1;
                            r_rem  <= r_rem - 1'b1;
                            r_tcnt <= '0;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.effect         = r_effect;
    assign bus.damage         = r_damage;
    assign bus.hp_player      = r_hp_p;
    assign bus.hp_enemy       = r_hp_e;
    assign bus.fainted_player = (r_hp_p == '0);
    assign bus.fainted_enemy  = (r_hp_e == '0);
endmodule

// File: tb/tb_battle_damage_calc.sv
// tb_battle_damage_calc: directed attacks scored against a queue of hand-computed results.
module tb_battle_damage_calc;
    typedef struct {
        logic [1:0] eff;
        logic [8:0] dmg;
        logic [7:0] hp_p;
        logic [7:0] hp_e;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst3_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    battle_damage_calc_if #(.HP_W(8), .POWER_W(8)) b1 ();
    battle_damage_calc_if #(.HP_W(8), .POWER_W(8)) b3 ();

    battle_damage_calc #(.HP_W(8), .POWER_W(8), .TICKS_PER_HP(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave));
    battle_damage_calc #(.HP_W(8), .POWER_W(8), .TICKS_PER_HP(3)) u3 (
        .i_clk(clk), .i_rst_n(rst3_n), .bus(b3.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && b1.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending attack");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("effect", b1.effect, e.eff);
                chk("damage", b1.damage, e.dmg);
                chk("hp_player", b1.hp_player, e.hp_p);
                chk("hp_enemy", b1.hp_enemy, e.hp_e);
            end
        end
    end

    task automatic push(input logic [1:0] eff, input logic [8:0] dmg, input logic [7:0] hp, input logic [7:0] he);
        exp_t e;
        e.eff = eff; e.dmg = dmg; e.hp_p = hp; e.hp_e = he;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic attack(input logic side, input logic [2:0] atk, input logic [2:0] def, input logic [7:0] pow);
        b1.start = 1'b1; b1.attacker_side = side; b1.atk_type = atk; b1.def_type = def; b1.move_power = pow;
        @(posedge clk);
        #1 b1.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b1.done) begin
                cyc(1);
                return;
            end
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic load(input logic [7:0] hp, input logic [7:0] he);
        b1.load_hp = 1'b1; b1.hp_init_player = hp; b1.hp_init_enemy = he;
        cyc(1);
        b1.load_hp = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_hp_player", b1.hp_player, 0);
        chk("rst_hp_enemy", b1.hp_enemy, 0);
        chk("rst_fainted_player", b1.fainted_player, 1);
        chk("rst_fainted_enemy", b1.fainted_enemy, 1);
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_effect", b1.effect, 0);
        chk("rst_damage", b1.damage, 0);
    endtask

    task automatic pulse3(input int n);
        repeat (n) begin
            b3.tick = 1'b1; cyc(1);
            b3.tick = 1'b0; cyc(1);
        end
    endtask

    initial begin
        b1.load_hp = 0; b1.hp_init_player = 0; b1.hp_init_enemy = 0; b1.start = 0;
        b1.attacker_side = 0; b1.atk_type = 0; b1.def_type = 0; b1.move_power = 0; b1.tick = 0;
        b3.load_hp = 0; b3.hp_init_player = 0; b3.hp_init_enemy = 0; b3.start = 0;
        b3.attacker_side = 0; b3.atk_type = 0; b3.def_type = 0; b3.move_power = 0; b3.tick = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1 rst_n = 1'b1; rst3_n = 1'b1;

        load(8'd100, 8'd100);
        b1.tick = 1'b1;
        push(2'b01, 9'd80, 8'd100, 8'd20); attack(1'b0, 3'd1, 3'd0, 8'd40); wait_done();
        push(2'b10, 9'd25, 8'd75, 8'd20);  attack(1'b1, 3'd2, 3'd2, 8'd50); wait_done();
        push(2'b00, 9'd30, 8'd75, 8'd0);   attack(1'b0, 3'd6, 3'd2, 8'd30); wait_done();
        @(negedge clk);
        chk("fainted_enemy", b1.fainted_enemy, 1);
        chk("fainted_player", b1.fainted_player, 0);

        push(2'b01, 9'd0, 8'd75, 8'd0);
        attack(1'b0, 3'd2, 3'd1, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_busy", b1.busy, 1);
            chk("zero_done", b1.done, (i == 2) ? 1 : 0);
        end
        @(negedge clk);
        chk("zero_idle", b1.busy, 0);

        push(2'b10, 9'd1, 8'd74, 8'd0);   attack(1'b1, 3'd2, 3'd2, 8'd1);   wait_done();
        push(2'b01, 9'd510, 8'd74, 8'd0); attack(1'b0, 3'd0, 3'd5, 8'd255); wait_done();

        load(8'd200, 8'd200);
        b1.tick = 1'b0;
        push(2'b00, 9'd100, 8'd200, 8'd100);
        attack(1'b0, 3'd6, 3'd6, 8'd100);
        cyc(4);
        b1.start = 1'b1; b1.atk_type = 3'd0; b1.def_type = 3'd2; b1.move_power = 8'd7;
        b1.load_hp = 1'b1; b1.hp_init_player = 8'd5; b1.hp_init_enemy = 8'd5;
        cyc(1);
        b1.start = 1'b0; b1.load_hp = 1'b0;
        @(negedge clk);
        chk("drain_hold_hp_enemy", b1.hp_enemy, 200);
        chk("drain_ignore_load", b1.hp_player, 200);
        chk("drain_busy", b1.busy, 1);
        b1.tick = 1'b1;
        wait_done();

        b1.load_hp = 1'b1; b1.hp_init_player = 8'd50; b1.hp_init_enemy = 8'd60;
        b1.start = 1'b1; b1.move_power = 8'd9;
        cyc(1);
        b1.load_hp = 1'b0; b1.start = 1'b0;
        @(negedge clk);
        chk("both_busy", b1.busy, 0);
        chk("both_hp_player", b1.hp_player, 50);
        chk("both_hp_enemy", b1.hp_enemy, 60);
        cyc(5);

        attack(1'b0, 3'd6, 3'd6, 8'd40);
        cyc(6);
        rst_n = 1'b0;
        cyc(1);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        b3.load_hp = 1'b1; b3.hp_init_player = 8'd10; b3.hp_init_enemy = 8'd10;
        cyc(1);
        b3.load_hp = 1'b0;
        b3.start = 1'b1; b3.atk_type = 3'd6; b3.def_type = 3'd6; b3.move_power = 8'd2;
        cyc(1);
        b3.start = 1'b0;
        cyc(10);
        @(negedge clk);
        chk("t3_no_tick_hp", b3.hp_enemy, 10);
        chk("t3_busy", b3.busy, 1);
        pulse3(2);
        @(negedge clk);
        chk("t3_two_ticks_hp", b3.hp_enemy, 10);
        pulse3(1);
        @(negedge clk);
        chk("t3_three_ticks_hp", b3.hp_enemy, 9);
        pulse3(3);
        @(negedge clk);
        chk("t3_six_ticks_hp", b3.hp_enemy, 8);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (b3.done) seen = 1'b1;
                else @(negedge clk);
            end
            chk("t3_done", seen, 1);
        end
        chk("t3_damage", b3.damage, 2);
        chk("t3_hp_player", b3.hp_player, 10);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
